// File: rtl/multi_zone_rect_tracker.sv
`default_nettype none
// ============================================================================
// Module   : multi_zone_rect_tracker
// Purpose  : Bounding-box tracker for a binary foreground video stream. The
//            active width is split into NUM_ZONES equal vertical bands; for
//            each band the min/max x/y and pixel count of foreground pixels
//            are accumulated over a frame. At the next frame edge, boxes with
//            at least MIN_PIX pixels are latched. Latched boxes are drawn as
//            BOX_COLOR borders over the RGB565 display stream.
// Ports    : clk, rst                 pixel clock, synchronous active-high reset
//            per_frame_vsync/href/clken  input syncs (vsync high in blanking)
//            per_img_bit              foreground bit of the current pixel
//            per_img_data             RGB565 pixel to be overlaid
//            lcd_x, lcd_y             display coordinates of per_img_data
//            post_frame_vsync/href/clken input syncs delayed one cycle
//            post_img                 overlaid pixel, aligned with post_* syncs
//            box_valid                bit z = zone z box valid for last frame
//            x_min/x_max/y_min/y_max  packed boxes, zone z at [z*CW +: CW]
// Config   : RECT_SMOOTH_EN - when defined, a zone valid in two consecutive
//            frames latches the average of the old and new coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module multi_zone_rect_tracker #(
    parameter int          CW        = 12,
    parameter int          IMG_W     = 1280,
    parameter int          NUM_ZONES = 4,
    parameter int          MIN_PIX   = 64,
    parameter int          CNT_W     = 20,
    parameter logic [15:0] BOX_COLOR = 16'hF800
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    per_frame_vsync,
    input  logic                    per_frame_href,
    input  logic                    per_frame_clken,
    input  logic                    per_img_bit,
    input  logic [15:0]             per_img_data,
    input  logic [CW-1:0]           lcd_x,
    input  logic [CW-1:0]           lcd_y,
    output logic                    post_frame_vsync,
    output logic                    post_frame_href,
    output logic                    post_frame_clken,
    output logic [15:0]             post_img,
    output logic [NUM_ZONES-1:0]    box_valid,
    output logic [NUM_ZONES*CW-1:0] x_min,
    output logic [NUM_ZONES*CW-1:0] x_max,
    output logic [NUM_ZONES*CW-1:0] y_min,
    output logic [NUM_ZONES*CW-1:0] y_max
);

    localparam int               c_zone_w    = IMG_W / NUM_ZONES;
    localparam logic [CW-1:0]    c_coord_max = {CW{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_min_pix   = CNT_W'(MIN_PIX);
    localparam logic [CW:0]      c_img_lim   = (CW+1)'(IMG_W);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_active = 2'd1;
    localparam logic [1:0] c_st_latch  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_clear;
    logic                 w_latch;
    logic                 w_acc_win;

    logic                 r_vsync_d;
    logic                 r_href_d;
    logic                 r_clken_d;
    logic [15:0]          r_post_img;
    logic                 w_frame_edge;
    logic                 w_href_fall;

    logic [CW-1:0]        r_x;
    logic [CW-1:0]        r_y;
    logic                 w_in_img;
    logic                 w_pix_fg;
    logic [NUM_ZONES-1:0] w_lt_hi;
    logic [NUM_ZONES-1:0] w_hit;

    assign w_frame_edge = per_frame_vsync & ~r_vsync_d;
    assign w_href_fall  = r_href_d & ~per_frame_href;

    // ------------------------------------------------------------------
    // Frame FSM. The first edge out of IDLE only opens the window, so a
    // partial frame seen after reset is never latched. The edge cycle
    // itself is excluded from accumulation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
            r_clken_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vsync_d <= per_frame_vsync;
            r_href_d  <= per_frame_href;
            r_clken_d <= per_frame_clken;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_latch     = 1'b0;
        w_acc_win   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_frame_edge) begin
                    w_state_nxt = c_st_active;
                    w_clear     = 1'b1;
                end
            end
            c_st_active: begin
                if (w_frame_edge) begin
                    w_state_nxt = c_st_latch;
                end else begin
                    w_acc_win = 1'b1;
                end
            end
            c_st_latch: begin
                // Boxes take the accumulators while the accumulators are
                // reset for the frame that has just started.
                w_state_nxt = c_st_active;
                w_latch     = 1'b1;
                w_clear     = 1'b1;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel coordinate counters, restarted on every frame edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_frame_edge) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_href_fall) begin
            r_x <= '0;
            if (r_y != c_coord_max) begin
                r_y <= r_y + 1'b1;
            end
        end else if (per_frame_clken && per_frame_href && (r_x != c_coord_max)) begin
            r_x <= r_x + 1'b1;
        end
    end

    assign w_in_img = ({1'b0, r_x} < c_img_lim);
    assign w_pix_fg = w_acc_win & per_frame_clken & per_frame_href & per_img_bit & w_in_img;

`ifdef RECT_SMOOTH_EN
    function automatic logic [CW-1:0] f_avg(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW:1];
    endfunction
`endif

    // ------------------------------------------------------------------
    // Per-zone accumulators, latched boxes and border detection.
    // ------------------------------------------------------------------
    genvar z;
    generate
        for (z = 0; z < NUM_ZONES; z++) begin : g_zone
            localparam logic [CW:0] c_hi = (CW+1)'((z + 1) * c_zone_w);

            logic             w_sel;
            logic [CW-1:0]    r_acc_xmin;
            logic [CW-1:0]    r_acc_xmax;
            logic [CW-1:0]    r_acc_ymin;
            logic [CW-1:0]    r_acc_ymax;
            logic [CNT_W-1:0] r_acc_cnt;
            logic             w_new_valid;
            logic [CW-1:0]    w_lat_xmin;
            logic [CW-1:0]    w_lat_xmax;
            logic [CW-1:0]    w_lat_ymin;
            logic [CW-1:0]    w_lat_ymax;
            logic             r_valid;
            logic [CW-1:0]    r_xmin;
            logic [CW-1:0]    r_xmax;
            logic [CW-1:0]    r_ymin;
            logic [CW-1:0]    r_ymax;

            // Zone membership: below this zone's upper bound and not below
            // the previous zone's, avoiding a divider on x.
            assign w_lt_hi[z] = ({1'b0, r_x} < c_hi);
            if (z == 0) begin : g_first
                assign w_sel = w_pix_fg & w_lt_hi[z];
            end else begin : g_rest
                assign w_sel = w_pix_fg & w_lt_hi[z] & ~w_lt_hi[z-1];
            end

            always_ff @(posedge clk) begin
                if (rst || w_clear) begin
                    r_acc_xmin <= c_coord_max;
                    r_acc_xmax <= '0;
                    r_acc_ymin <= c_coord_max;
                    r_acc_ymax <= '0;
                    r_acc_cnt  <= '0;
                end else if (w_sel) begin
                    if (r_x < r_acc_xmin) r_acc_xmin <= r_x;
                    if (r_x > r_acc_xmax) r_acc_xmax <= r_x;
                    if (r_y < r_acc_ymin) r_acc_ymin <= r_y;
                    if (r_y > r_acc_ymax) r_acc_ymax <= r_y;
                    if (r_acc_cnt != c_cnt_max) r_acc_cnt <= r_acc_cnt + 1'b1;
                end
            end

            assign w_new_valid = (r_acc_cnt >= c_min_pix);

            always_comb begin
                w_lat_xmin = '0;
                w_lat_xmax = '0;
                w_lat_ymin = '0;
                w_lat_ymax = '0;
                if (w_new_valid) begin
                    w_lat_xmin = r_acc_xmin;
                    w_lat_xmax = r_acc_xmax;
                    w_lat_ymin = r_acc_ymin;
                    w_lat_ymax = r_acc_ymax;
`ifdef RECT_SMOOTH_EN
                    if (r_valid) begin
                        w_lat_xmin = f_avg(r_xmin, r_acc_xmin);
                        w_lat_xmax = f_avg(r_xmax, r_acc_xmax);
                        w_lat_ymin = f_avg(r_ymin, r_acc_ymin);
                        w_lat_ymax = f_avg(r_ymax, r_acc_ymax);
                    end
`endif
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_xmin  <= '0;
                    r_xmax  <= '0;
                    r_ymin  <= '0;
                    r_ymax  <= '0;
                end else if (w_latch) begin
                    r_valid <= w_new_valid;
                    r_xmin  <= w_lat_xmin;
                    r_xmax  <= w_lat_xmax;
                    r_ymin  <= w_lat_ymin;
                    r_ymax  <= w_lat_ymax;
                end
            end

            assign w_hit[z] = r_valid &
                (((lcd_x == r_xmin) | (lcd_x == r_xmax)) & (lcd_y >= r_ymin) & (lcd_y <= r_ymax) |
                 ((lcd_y == r_ymin) | (lcd_y == r_ymax)) & (lcd_x >= r_xmin) & (lcd_x <= r_xmax));

            assign box_valid[z]       = r_valid;
            assign x_min[z*CW +: CW]  = r_xmin;
            assign x_max[z*CW +: CW]  = r_xmax;
            assign y_min[z*CW +: CW]  = r_ymin;
            assign y_max[z*CW +: CW]  = r_ymax;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Overlay output, one cycle behind the input stream.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !per_frame_href) begin
            r_post_img <= '0;
        end else if (|w_hit) begin
            r_post_img <= BOX_COLOR;
        end else begin
            r_post_img <= per_img_data;
        end
    end

    assign post_img         = r_post_img;
    assign post_frame_vsync = r_vsync_d;
    assign post_frame_href  = r_href_d;
    assign post_frame_clken = r_clken_d;

endmodule

`default_nettype wire

// File: tb/tb_multi_zone_rect_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_zone_rect_tracker
// Purpose  : Self-checking bench for multi_zone_rect_tracker. Frames are
//            described as rectangles plus random speckle; every foreground
//            pixel driven is recorded as an (x,y) pair and the expected boxes
//            are computed from that list at each frame edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_zone_rect_tracker;

    localparam int CW      = 12;
    localparam int IMG_W   = 1280;
    localparam int NZ      = 4;
    localparam int MIN_PIX = 64;
    localparam int CNT_W   = 20;
    localparam int ZONE_W  = IMG_W / NZ;

    logic             clk = 1'b0;
    logic             rst;
    logic             vsync, href, clken, bitv;
    logic [15:0]      data;
    logic [CW-1:0]    lcd_x, lcd_y;
    logic             post_frame_vsync, post_frame_href, post_frame_clken;
    logic [15:0]      post_img;
    logic [NZ-1:0]    box_valid;
    logic [NZ*CW-1:0] x_min, x_max, y_min, y_max;

    always #5 clk = ~clk;

    multi_zone_rect_tracker #(
        .CW(CW), .IMG_W(IMG_W), .NUM_ZONES(NZ), .MIN_PIX(MIN_PIX),
        .CNT_W(CNT_W), .BOX_COLOR(16'hF800)
    ) dut (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_bit(bitv), .per_img_data(data), .lcd_x(lcd_x), .lcd_y(lcd_y),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .post_img(post_img),
        .box_valid(box_valid), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
    );

    typedef struct { int x; int y; } pix_t;
    typedef struct { int x0; int x1; int y0; int y1; } rect_t;

    int    n_cmp = 0;
    int    n_fail = 0;
    pix_t  fgq[$];
    rect_t rq[$];
    int    dens;
    int    armed;
    int    e_valid[NZ], e_xmin[NZ], e_xmax[NZ], e_ymin[NZ], e_ymax[NZ];

    logic          p_rst, p_vs, p_hr, p_ck;
    logic [15:0]   p_data;
    logic [CW-1:0] p_lx, p_ly;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_img(input logic hr, input logic [15:0] d, input int lx, input int ly);
        if (!hr) return 16'h0000;
        for (int z = 0; z < NZ; z++) begin
            if (e_valid[z] != 0) begin
                if (((lx == e_xmin[z]) || (lx == e_xmax[z])) && (ly >= e_ymin[z]) && (ly <= e_ymax[z]))
                    return 16'hF800;
                if (((ly == e_ymin[z]) || (ly == e_ymax[z])) && (lx >= e_xmin[z]) && (lx <= e_xmax[z]))
                    return 16'hF800;
            end
        end
        return d;
    endfunction

    task automatic clear_model();
        for (int z = 0; z < NZ; z++) begin
            e_valid[z] = 0; e_xmin[z] = 0; e_xmax[z] = 0; e_ymin[z] = 0; e_ymax[z] = 0;
        end
    endtask

    // One clock: remember what was driven, advance, check the delayed stream.
    task automatic step();
        p_rst = rst; p_vs = vsync; p_hr = href; p_ck = clken;
        p_data = data; p_lx = lcd_x; p_ly = lcd_y;
        @(posedge clk);
        #1;
        if (p_rst) begin
            chk("post_rst", {post_frame_vsync, post_frame_href, post_frame_clken, post_img}, 0);
        end else begin
            chk("post_sync", {post_frame_vsync, post_frame_href, post_frame_clken}, {p_vs, p_hr, p_ck});
            chk("post_img", post_img, exp_img(p_hr, p_data, int'(p_lx), int'(p_ly)));
        end
    endtask

    task automatic model_latch();
        int cnt[NZ], mnx[NZ], mxx[NZ], mny[NZ], mxy[NZ];
        int z;
        for (int k = 0; k < NZ; k++) begin
            cnt[k] = 0; mnx[k] = (1 << CW) - 1; mxx[k] = 0; mny[k] = (1 << CW) - 1; mxy[k] = 0;
        end
        foreach (fgq[i]) begin
            if (fgq[i].x < IMG_W) begin
                z = fgq[i].x / ZONE_W;
                cnt[z]++;
                if (fgq[i].x < mnx[z]) mnx[z] = fgq[i].x;
                if (fgq[i].x > mxx[z]) mxx[z] = fgq[i].x;
                if (fgq[i].y < mny[z]) mny[z] = fgq[i].y;
                if (fgq[i].y > mxy[z]) mxy[z] = fgq[i].y;
            end
        end
        for (int k = 0; k < NZ; k++) begin
            if (cnt[k] < MIN_PIX) begin
                e_valid[k] = 0; e_xmin[k] = 0; e_xmax[k] = 0; e_ymin[k] = 0; e_ymax[k] = 0;
            end else begin
`ifdef RECT_SMOOTH_EN
                if (e_valid[k] != 0) begin
                    e_xmin[k] = (e_xmin[k] + mnx[k]) / 2; e_xmax[k] = (e_xmax[k] + mxx[k]) / 2;
                    e_ymin[k] = (e_ymin[k] + mny[k]) / 2; e_ymax[k] = (e_ymax[k] + mxy[k]) / 2;
                end else begin
                    e_xmin[k] = mnx[k]; e_xmax[k] = mxx[k]; e_ymin[k] = mny[k]; e_ymax[k] = mxy[k];
                end
`else
                e_xmin[k] = mnx[k]; e_xmax[k] = mxx[k]; e_ymin[k] = mny[k]; e_ymax[k] = mxy[k];
`endif
                e_valid[k] = 1;
            end
        end
    endtask

    task automatic check_boxes();
        for (int z = 0; z < NZ; z++) begin
            chk($sformatf("valid%0d", z), box_valid[z], e_valid[z]);
            chk($sformatf("x_min%0d", z), x_min[z*CW +: CW], e_xmin[z]);
            chk($sformatf("x_max%0d", z), x_max[z*CW +: CW], e_xmax[z]);
            chk($sformatf("y_min%0d", z), y_min[z*CW +: CW], e_ymin[z]);
            chk($sformatf("y_max%0d", z), y_max[z*CW +: CW], e_ymax[z]);
        end
    endtask

    // Frame edge: vsync pulse, model update, box check.
    task automatic send_edge();
        href = 0; clken = 0; bitv = 0;
        vsync = 1;
        step();
        step();
        if (armed != 0) model_latch();
        armed = 1;
        fgq.delete();
        step();
        step();
        check_boxes();
        vsync = 0;
        step();
        step();
    endtask

    task automatic pixel(input int x, input int y, input bit fg);
        if ($urandom_range(3) == 0) begin
            href = 1; clken = 0; bitv = 1'($urandom_range(1)); data = 16'($urandom);
            step();
        end
        href = 1; clken = 1; bitv = fg; data = 16'($urandom);
        lcd_x = CW'(x); lcd_y = CW'(y);
        step();
        if (fg) fgq.push_back('{x, y});
    endtask

    // Lines of width w; a reset pulse is inserted before line rst_line.
    task automatic send_frame(input int w, input int h, input int rst_line);
        bit fg;
        for (int y = 0; y < h; y++) begin
            if (y == rst_line) begin
                rst = 1;
                repeat (3) step();
                rst = 0;
                armed = 0;
                fgq.delete();
                clear_model();
            end
            for (int x = 0; x < w; x++) begin
                fg = 0;
                foreach (rq[i])
                    if (x >= rq[i].x0 && x <= rq[i].x1 && y >= rq[i].y0 && y <= rq[i].y1) fg = 1;
                if (dens > 0 && $urandom_range(99) < dens) fg = 1;
                pixel(x, y, fg);
            end
            href = 0; clken = 0; bitv = 0;
            repeat (3) step();
        end
    endtask

    task automatic probe(input int px, input int py, output logic [15:0] d);
        href = 1; clken = 0; bitv = 0;
        lcd_x = CW'(px); lcd_y = CW'(py); data = 16'($urandom);
        d = data;
        step();
    endtask

    logic [15:0] pd;
    int          w, h, zz;

    initial begin
        rst = 1; vsync = 0; href = 0; clken = 0; bitv = 0; data = 0; lcd_x = 0; lcd_y = 0;
        armed = 0; dens = 0;
        clear_model();
        repeat (3) step();
        rst = 0;
        step();
        chk("reset_box_valid", box_valid, 0);
        chk("reset_x_min", x_min, 0);
        chk("reset_y_max", y_max, 0);
        chk("reset_post_img", post_img, 0);

        // First edge after reset only opens the window.
        send_edge();
        chk("edge1_valid", box_valid, 0);

        // Partial frame interrupted by reset: next edge must not latch.
        rq.delete(); rq.push_back('{0, 99, 0, 5});
        send_frame(120, 6, 3);
        send_edge();
        chk("after_rst_edge_valid", box_valid, 0);

        // 100 fg pixels in zone 0, latched on the second edge.
        rq.delete(); rq.push_back('{5, 24, 0, 4});
        send_frame(60, 5, -1);
        send_edge();
        chk("f100_valid", box_valid, 4'b0001);
        chk("f100_x_max0", x_max[CW-1:0], 24);

        // 40x10 block.
        rq.delete(); rq.push_back('{10, 49, 20, 29});
        send_frame(60, 32, -1);
        send_edge();
        chk("blk_valid", box_valid, 4'b0001);
        chk("blk_x_min0", x_min[CW-1:0], 10);
        chk("blk_x_max0", x_max[CW-1:0], 49);
        chk("blk_y_min0", y_min[CW-1:0], 20);
        chk("blk_y_max0", y_max[CW-1:0], 29);

        // Blob across the zone 0/1 boundary; overlay probes on the block box.
        rq.delete(); rq.push_back('{300, 340, 5, 8});
        send_frame(350, 10, -1);
        probe(10, 25, pd); chk("ovl_10_25", post_img, 16'hF800);
        probe(30, 20, pd); chk("ovl_30_20", post_img, 16'hF800);
        probe(30, 25, pd); chk("ovl_30_25", post_img, pd);
        probe(50, 25, pd); chk("ovl_50_25", post_img, pd);
        href = 0; step();
        send_edge();
        chk("span_valid", box_valid, 4'b0011);
        chk("span_x_max0", x_max[CW-1:0], 319);
        chk("span_x_min1", x_min[CW +: CW], 320);
        chk("span_x_max1", x_max[CW +: CW], 340);

        // 63 then 64 pixels in zone 2.
        rq.delete(); rq.push_back('{640, 702, 0, 0});
        send_frame(710, 1, -1);
        send_edge();
        chk("z2_63_valid", box_valid, 4'b0000);
        rq.delete(); rq.push_back('{640, 703, 0, 0});
        send_frame(710, 1, -1);
        send_edge();
        chk("z2_64_valid", box_valid, 4'b0100);

        // Two consecutive frames with different x_min in zone 0.
        rq.delete(); rq.push_back('{100, 109, 0, 9});
        send_frame(215, 10, -1);
        send_edge();
        rq.delete(); rq.push_back('{200, 209, 0, 9});
        send_frame(215, 10, -1);
        send_edge();
`ifdef RECT_SMOOTH_EN
        chk("smooth_x_min0", x_min[CW-1:0], 150);
`else
        chk("raw_x_min0", x_min[CW-1:0], 200);
`endif

        // Pixels past the active width are ignored.
        rq.delete(); rq.push_back('{1250, 1299, 0, 2});
        send_frame(1300, 3, -1);
        send_edge();
        chk("edge_x_max3", x_max[3*CW +: CW], 1279);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            rq.delete();
            w = $urandom_range(400, 100);
            h = $urandom_range(8, 3);
            for (int r = 0; r < 2; r++) begin
                int x0, y0;
                x0 = $urandom_range(w - 1);
                y0 = $urandom_range(h - 1);
                rq.push_back('{x0, x0 + $urandom_range(60, 5), y0, y0 + $urandom_range(4)});
            end
            dens = $urandom_range(6);
            send_frame(w, h, -1);
            for (int p = 0; p < 8; p++) begin
                zz = $urandom_range(NZ - 1);
                probe(e_xmin[zz] + $urandom_range(2) - 1, e_ymin[zz] + $urandom_range(2) - 1, pd);
            end
            href = 0; step();
            send_edge();
        end
        dens = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
